// File: rtl/dct_it_math_stream.sv
// Flow-controlled 1-D 8-point binDCT inverse datapath: entry, six lifting/butterfly stages, output.
// Optional macro DCT_IT_MATH_STREAM_SAT_EN clamps the narrowed outputs instead of wrapping them.
module dct_it_math_stream #(
  parameter int W_I       = 16,
  parameter int W_O       = 16,
  parameter int FRAC      = 3,
  parameter int OUT_SHIFT = 5,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [8*W_I-1:0]     s_data,
  input  logic [TAG_W-1:0]     s_tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [8*W_O-1:0]     m_data,
  output logic [TAG_W-1:0]     m_tag
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both high.
  // The whole pipe advances on en; s_ready is en, so input stalls exactly when the output stalls.

  localparam int WN = W_I + FRAC + 2;
  localparam int RW = (WN > W_O) ? WN : W_O;

  typedef logic signed [WN-1:0] wn_t;

  localparam logic signed [WN:0] Q_HALF    = (WN+1)'(1) <<< (FRAC - 1);
  localparam logic signed [WN:0] Q_HALF_M1 = Q_HALF - (WN+1)'(1);

`ifdef DCT_IT_MATH_STREAM_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-W_O+1){1'b0}}, {(W_O-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-W_O+1){1'b1}}, {(W_O-1){1'b0}}};
`endif

  // Round to the nearest multiple of 2^FRAC, ties away from zero; one extra bit absorbs the offset.
  function automatic wn_t q_round(input wn_t v);
    logic signed [WN:0] s;
    s = {v[WN-1], v};
    if (v[WN-1]) s = s + Q_HALF_M1;
    else         s = s + Q_HALF;
    s = (s >>> FRAC) <<< FRAC;
    return s[WN-1:0];
  endfunction

  function automatic logic [W_O-1:0] narrow(input wn_t y);
    logic signed [RW-1:0] r;
    r = RW'(y >>> OUT_SHIFT);
`ifdef DCT_IT_MATH_STREAM_SAT_EN
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
`endif
    return r[W_O-1:0];
  endfunction

  logic en;
  assign en      = ~m_valid | m_ready;
  assign s_ready = en;

  logic [6:0]       vld;
  logic [TAG_W-1:0] tag_q [7];

  wn_t e_q  [8], s1_q [8], s2_q [8], s3_q [8], s4_q [8], s5_q [8], s6_q [8];
  wn_t e_d  [8], s1_d [8], s2_d [8], s3_d [8], s4_d [8], s5_d [8], s6_d [8];
  logic [8*W_O-1:0] o_d;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      e_d[i] = {{(WN-W_I){s_data[i*W_I+W_I-1]}}, s_data[i*W_I +: W_I]} <<< FRAC;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) s1_d[i] = e_q[i];
    s1_d[1] = q_round(e_q[0] >>> 1) - e_q[1];
    s1_d[3] = e_q[3] - q_round((e_q[2] >>> 3) + (e_q[2] >>> 2));
    s1_d[6] = q_round(e_q[5] >>> 1) + e_q[6];
  end

  always_comb begin
    for (int i = 0; i < 8; i++) s2_d[i] = s1_q[i];
    s2_d[0] = s1_q[0] - s1_q[1];
    s2_d[2] = q_round((s1_q[3] >>> 3) + (s1_q[3] >>> 2)) + s1_q[2];
    s2_d[4] = q_round(s1_q[7] >>> 3) + s1_q[4];
    s2_d[5] = s1_q[5] - q_round((s1_q[6] >>> 3) + (s1_q[6] >>> 2) + (s1_q[6] >>> 1));
  end

  always_comb begin
    s3_d[0] = s2_q[0] + s2_q[3];
    s3_d[1] = s2_q[1] + s2_q[2];
    s3_d[2] = s2_q[1] - s2_q[2];
    s3_d[3] = s2_q[0] - s2_q[3];
    s3_d[4] = s2_q[4] + s2_q[5];
    s3_d[5] = s2_q[4] - s2_q[5];
    s3_d[6] = s2_q[7] - s2_q[6];
    s3_d[7] = s2_q[6] + s2_q[7];
  end

  always_comb begin
    for (int i = 0; i < 8; i++) s4_d[i] = s3_q[i];
    s4_d[5] = q_round((s3_q[6] >>> 3) + (s3_q[6] >>> 1)) - s3_q[5];
  end

  // S5 consumes the x5 that S4 just produced, hence its own register stage.
  always_comb begin
    for (int i = 0; i < 8; i++) s5_d[i] = s4_q[i];
    s5_d[6] = s4_q[6] - q_round((s4_q[5] >>> 3) + (s4_q[5] >>> 2));
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s6_d[i]   = s5_q[i] + s5_q[7-i];
      s6_d[4+i] = s5_q[3-i] - s5_q[4+i];
    end
  end

  always_comb begin
    o_d = '0;
    for (int i = 0; i < 8; i++) o_d[i*W_O +: W_O] = narrow(s6_q[i]);
  end

  // Data registers load junk behind bubbles; vld masks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
      for (int i = 0; i < 7; i++) tag_q[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        e_q[i]  <= '0;
        s1_q[i] <= '0;
        s2_q[i] <= '0;
        s3_q[i] <= '0;
        s4_q[i] <= '0;
        s5_q[i] <= '0;
        s6_q[i] <= '0;
      end
    end else if (en) begin
      vld      <= {vld[5:0], s_valid};
      m_valid  <= vld[6];
      tag_q[0] <= s_tag;
      for (int i = 1; i < 7; i++) tag_q[i] <= tag_q[i-1];
      m_tag    <= tag_q[6];
      m_data   <= o_d;
      for (int i = 0; i < 8; i++) begin
        e_q[i]  <= e_d[i];
        s1_q[i] <= s1_d[i];
        s2_q[i] <= s2_d[i];
        s3_q[i] <= s3_d[i];
        s4_q[i] <= s4_d[i];
        s5_q[i] <= s5_d[i];
        s6_q[i] <= s6_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dct_it_math_stream.sv
// Directed bench for dct_it_math_stream: DC, latency, streaming, backpressure, narrowing, mid-stream reset.
// A second instance with W_O=8 shares the inputs to exercise output narrowing.
module tb_dct_it_math_stream;

  localparam int W_I   = 16;
  localparam int W_O   = 16;
  localparam int TAG_W = 4;
  localparam int DW    = 8 * W_O;
  localparam int EW    = DW + TAG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [8*W_I-1:0] s_data;
  logic [TAG_W-1:0] s_tag;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic [TAG_W-1:0] m_tag;

  logic             sat_s_ready;
  logic             sat_m_valid;
  logic [63:0]      sat_m_data;
  logic [TAG_W-1:0] sat_m_tag;

  always #5 clk = ~clk;

  dct_it_math_stream dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag)
  );

  dct_it_math_stream #(.W_O(8)) dut_narrow (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data), .s_tag(s_tag),
    .m_valid(sat_m_valid), .m_ready(m_ready), .m_data(sat_m_data), .m_tag(sat_m_tag)
  );

  int               checks = 0;
  int               errors = 0;
  int               n_acc  = 0;
  int               n_out  = 0;
  int               lat;
  logic             acc    = 1'b0;
  logic [TAG_W-1:0] tag_ctr = '0;
  logic [DW-1:0]    hold_data;
  logic [TAG_W-1:0] hold_tag;
  logic [63:0]      sat_exp;
  logic [EW-1:0]    exp_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic written with integer division rather than shifts/masks.
  function automatic longint qr(input longint v);
    longint a;
    a = (v < 0) ? -v : v;
    a = ((a + 4) / 8) * 8;
    return (v < 0) ? -a : a;
  endfunction

  function automatic longint fl(input longint v, input int n);
    longint d;
    d = longint'(1) << n;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic logic [DW-1:0] model(input logic [8*W_I-1:0] d);
    longint x [8], t [8], u [8], y [8];
    longint r;
    logic [DW-1:0] res;
    for (int i = 0; i < 8; i++) x[i] = longint'($signed(d[i*W_I +: W_I])) * 8;
    for (int i = 0; i < 8; i++) t[i] = x[i];
    t[1] = qr(fl(x[0], 1)) - x[1];
    t[3] = x[3] - qr(fl(x[2], 3) + fl(x[2], 2));
    t[6] = qr(fl(x[5], 1)) + x[6];
    for (int i = 0; i < 8; i++) u[i] = t[i];
    u[0] = t[0] - t[1];
    u[2] = qr(fl(t[3], 3) + fl(t[3], 2)) + t[2];
    u[4] = qr(fl(t[7], 3)) + t[4];
    u[5] = t[5] - qr(fl(t[6], 3) + fl(t[6], 2) + fl(t[6], 1));
    x[0] = u[0] + u[3]; x[1] = u[1] + u[2]; x[2] = u[1] - u[2]; x[3] = u[0] - u[3];
    x[4] = u[4] + u[5]; x[5] = u[4] - u[5]; x[6] = u[7] - u[6]; x[7] = u[6] + u[7];
    x[5] = qr(fl(x[6], 3) + fl(x[6], 1)) - x[5];
    x[6] = x[6] - qr(fl(x[5], 3) + fl(x[5], 2));
    for (int i = 0; i < 4; i++) begin
      y[i]   = x[i] + x[7-i];
      y[4+i] = x[3-i] - x[4+i];
    end
    res = '0;
    for (int i = 0; i < 8; i++) begin
      r = fl(y[i], 5);
`ifdef DCT_IT_MATH_STREAM_SAT_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`endif
      res[i*W_O +: W_O] = r[W_O-1:0];
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] rep16(input int v);
    logic [DW-1:0] res;
    for (int i = 0; i < 8; i++) res[i*16 +: 16] = v[15:0];
    return res;
  endfunction

  function automatic logic [63:0] rep8(input int v);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) res[i*8 +: 8] = v[7:0];
    return res;
  endfunction

  task automatic rand_vec();
    for (int i = 0; i < 8; i++) begin
      int v;
      v = int'($urandom_range(16383, 0)) - 8192;
      s_data[i*W_I +: W_I] = v[W_I-1:0];
    end
    s_tag   = tag_ctr;
    tag_ctr = tag_ctr + 1'b1;
  endtask

  // One clock: sample handshakes away from the edge, score, then advance to the next negedge.
  task automatic cycle();
    logic [EW-1:0] e;
    #1;
    acc = s_valid && s_ready;
    if (acc) begin
      exp_q.push_back({model(s_data), s_tag});
      n_acc++;
    end
    if (m_valid && m_ready) begin
      n_out++;
      chk("sb_nonempty", DW'(exp_q.size() > 0), DW'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_data", m_data, e[EW-1:TAG_W]);
        chk("sb_tag", DW'(m_tag), DW'(e[TAG_W-1:0]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called right after the accept cycle; returns cycles from accept to m_valid.
  task automatic measure_latency(output int l);
    l = 1;
    while (!m_valid && l < 40) begin
      cycle();
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_tag = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", DW'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_tag", DW'(m_tag), '0);
    rst = 1'b0;
    #1 chk("rst_s_ready", DW'(s_ready), DW'(1));
    @(negedge clk);

    // DC: coefficient 0 = 64 gives 8 in every sample
    s_valid = 1'b1; s_data = '0; s_data[W_I-1:0] = 16'd64; s_tag = 4'd5;
    cycle();
    s_valid = 1'b0;
    measure_latency(lat);
    chk("dc_latency", DW'(lat), DW'(8));
    chk("dc_m_data", m_data, rep16(8));
    chk("dc_m_tag", DW'(m_tag), DW'(5));
    chk("dc_narrow_data", DW'(sat_m_data), DW'(rep8(8)));
    cycle();

    // Negative DC followed back-to-back by an all-zero vector
    s_valid = 1'b1; s_data = '0; s_data[W_I-1:0] = 16'hFFC0; s_tag = 4'd6;
    cycle();
    s_data = '0; s_tag = 4'd7;
    cycle();
    s_valid = 1'b0;
    measure_latency(lat);
    chk("neg_latency", DW'(lat), DW'(7));
    chk("neg_m_data", m_data, rep16(-8));
    chk("neg_m_tag", DW'(m_tag), DW'(6));
    chk("neg_narrow_data", DW'(sat_m_data), DW'(rep8(-8)));
    cycle();
    chk("zero_m_valid", DW'(m_valid), DW'(1));
    chk("zero_m_data", m_data, '0);
    chk("zero_m_tag", DW'(m_tag), DW'(7));
    cycle();

    // 16 random vectors back-to-back
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1;
      rand_vec();
      #1 chk("stream_s_ready", DW'(s_ready), DW'(1));
      if (k >= 8) chk("stream_m_valid", DW'(m_valid), DW'(1));
      cycle();
    end
    s_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("stream_tail_valid", DW'(m_valid), DW'(1));
      cycle();
    end
    chk("stream_drained", DW'(exp_q.size()), '0);
    chk("stream_idle", DW'(m_valid), '0);

    // Backpressure: stall after 3 accepts, pipe fills, then random m_ready
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      rand_vec();
      cycle();
    end
    m_ready = 1'b0;
    rand_vec();
    for (int k = 0; k < 20 && !m_valid; k++) begin
      cycle();
      if (acc) rand_vec();
    end
    #1;
    chk("bp_s_ready_low", DW'(s_ready), '0);
    chk("bp_m_valid", DW'(m_valid), DW'(1));
    hold_data = m_data;
    hold_tag  = m_tag;
    repeat (4) cycle();
    chk("bp_hold_data", m_data, hold_data);
    chk("bp_hold_tag", DW'(m_tag), DW'(hold_tag));
    chk("bp_hold_valid", DW'(m_valid), DW'(1));
    chk("bp_inflight", DW'(exp_q.size()), DW'(8));
    for (int k = 0; k < 80; k++) begin
      m_ready = 1'($urandom_range(1, 0));
      if (!s_valid || acc) begin
        s_valid = 1'($urandom_range(1, 0));
        rand_vec();
      end
      cycle();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) cycle();
    chk("bp_drained", DW'(exp_q.size()), '0);
    chk("bp_count", DW'(n_out), DW'(n_acc));

    // Narrowing: model value 2048 fits 16 bits, overflows 8 bits
    s_valid = 1'b1; s_data = '0; s_data[W_I-1:0] = 16'd16384; s_tag = 4'd3;
    cycle();
    s_valid = 1'b0;
    measure_latency(lat);
`ifdef DCT_IT_MATH_STREAM_SAT_EN
    sat_exp = rep8(127);
`else
    sat_exp = rep8(0);
`endif
    chk("sat_latency", DW'(lat), DW'(8));
    chk("sat_wide_data", m_data, rep16(2048));
    chk("sat_narrow_data", DW'(sat_m_data), DW'(sat_exp));
    chk("sat_narrow_tag", DW'(sat_m_tag), DW'(3));
    cycle();

    // Reset with 5 vectors in flight
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      rand_vec();
      cycle();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    cycle();
    chk("mid_rst_m_valid", DW'(m_valid), '0);
    chk("mid_rst_m_data", m_data, '0);
    chk("mid_rst_m_tag", DW'(m_tag), '0);
    rst = 1'b0;
    #1 chk("post_rst_s_ready", DW'(s_ready), DW'(1));
    for (int k = 0; k < 12; k++) begin
      chk("no_stale", DW'(m_valid), '0);
      cycle();
    end
    s_valid = 1'b1; s_data = '0; s_data[W_I-1:0] = 16'd64; s_tag = 4'd9;
    cycle();
    s_valid = 1'b0;
    measure_latency(lat);
    chk("post_rst_latency", DW'(lat), DW'(8));
    chk("post_rst_data", m_data, rep16(8));
    chk("post_rst_tag", DW'(m_tag), DW'(9));
    cycle();
    chk("final_drained", DW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
